// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared encodings and constants for the multiply/divide unit
package md_pkg;

  localparam logic [1:0] OP_DIV   = 2'b11;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_MULTU = 2'b00;

  localparam int DIV_ITERS   = 32;
  localparam int MUL_LAT_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } md_state_e;

endpackage

// File: rtl/div_iter.sv
// rtl/div_iter.sv - 32-bit radix-2 restoring divider core, one quotient bit per step
module div_iter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic [5:0]  count
);

  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dsr_q, dsr_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [32:0] partial;
  logic [32:0] diff;

  // The quotient register doubles as the dividend shifter: bits leave the top as quotient bits enter the bottom.
  always_comb begin
    quo_d   = quo_q;
    rem_d   = rem_q;
    dsr_d   = dsr_q;
    cnt_d   = cnt_q;
    partial = {rem_q, quo_q[31]};
    diff    = partial - {1'b0, dsr_q};
    if (load) begin
      quo_d = dividend;
      rem_d = 32'd0;
      dsr_d = divisor;
      cnt_d = 6'd0;
    end else if (step) begin
      cnt_d = cnt_q + 6'd1;
      if (!diff[32]) begin
        rem_d = diff[31:0];
        quo_d = {quo_q[30:0], 1'b1};
      end else begin
        rem_d = partial[31:0];
        quo_d = {quo_q[30:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q <= 32'd0;
      rem_q <= 32'd0;
      dsr_q <= 32'd0;
      cnt_q <= 6'd0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dsr_q <= dsr_d;
      cnt_q <= cnt_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign count     = cnt_q;

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multi-cycle multiply/divide unit owning the HI/LO registers
module mult_div_unit
  import md_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        hilo,
  input  logic        we,
  input  logic [1:0]  op,
  input  logic        madd,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);

  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  md_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        sgn_q, sgn_d;
  logic        madd_q, madd_d;
  logic        quo_neg_q, quo_neg_d;
  logic        rem_neg_q, rem_neg_d;
  logic        div_zero_q, div_zero_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic        div_load, div_step;
  logic [31:0] mag_a, mag_b, div_quo, div_rem;
  logic [5:0]  div_cnt;
  logic [63:0] ext_a, ext_b, prod;

  assign mag_a = (op[0] && src_a[31]) ? -src_a : src_a;
  assign mag_b = (op[0] && src_b[31]) ? -src_b : src_b;

  // Sign-extending to 64 bits lets one truncated multiplier serve both mult and multu.
  assign ext_a = sgn_q ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
  assign ext_b = sgn_q ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
  assign prod  = ext_a * ext_b;

  div_iter u_div_iter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (div_load),
    .step      (div_step),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .quotient  (div_quo),
    .remainder (div_rem),
    .count     (div_cnt)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    sgn_d      = sgn_q;
    madd_d     = madd_q;
    quo_neg_d  = quo_neg_q;
    rem_neg_d  = rem_neg_q;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_load   = 1'b0;
    div_step   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d    = src_a;
          b_d    = src_b;
          sgn_d  = op[0];
          madd_d = madd && !op[1];
          if (op[1]) begin
            state_d    = ST_DIV;
            div_load   = 1'b1;
            quo_neg_d  = op[0] && (src_a[31] ^ src_b[31]);
            rem_neg_d  = op[0] && src_a[31];
            div_zero_d = (src_b == 32'd0);
          end else begin
            state_d = ST_MUL;
            cnt_d   = CW'(MUL_LAT - 1);
          end
        end else if (we) begin
          if (hilo) lo_d = src_a;
          else      hi_d = src_a;
        end
      end
      ST_MUL: begin
        if (cnt_q == '0) begin
          {hi_d, lo_d} = madd_q ? ({hi_q, lo_q} + prod) : prod;
          state_d      = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DIV: begin
        div_step = 1'b1;
        if (div_cnt == 6'(DIV_ITERS - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        // A zero divisor still spends the full latency but leaves HI/LO alone.
        if (!div_zero_q) begin
          lo_d = quo_neg_q ? -div_quo : div_quo;
          hi_d = rem_neg_q ? -div_rem : div_rem;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      sgn_q      <= 1'b0;
      madd_q     <= 1'b0;
      quo_neg_q  <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sgn_q      <= sgn_d;
      madd_q     <= madd_d;
      quo_neg_q  <= quo_neg_d;
      rem_neg_q  <= rem_neg_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign rd_data = hilo ? lo_q : hi_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed-vector self-checking bench for mult_div_unit
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        hilo = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  op = 2'b00;
  logic        madd = 1'b0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        busy;
  logic [31:0] hi, lo, rd_data;

  int n_vec = 0;
  int n_bad = 0;
  int n;

  mult_div_unit #(.MUL_LAT(5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .hilo    (hilo),
    .we      (we),
    .op      (op),
    .madd    (madd),
    .src_a   (src_a),
    .src_b   (src_b),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo),
    .rd_data (rd_data)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; drives start for one edge, then counts busy cycles (bounded).
  task automatic launch(input logic [1:0] o, input logic m, input logic [31:0] a,
                        input logic [31:0] b, output int cycles);
    start = 1'b1; op = o; madd = m; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0; madd = 1'b0;
    cycles = 0;
    while (busy && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic move_to(input logic sel, input logic [31:0] val);
    we = 1'b1; hilo = sel; src_a = val;
    @(negedge clk);
    we = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_eq("reset_busy", 64'(busy), 64'd0);
    check_eq("reset_hi", 64'(hi), 64'd0);
    check_eq("reset_lo", 64'(lo), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    launch(2'b00, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
    check_eq("multu_lat", 64'(n), 64'd5);
    check_eq("multu_hi", 64'(hi), 64'hFFFF_FFFE);
    check_eq("multu_lo", 64'(lo), 64'h0000_0001);

    move_to(1'b0, 32'h0);
    move_to(1'b1, 32'h10);
    launch(2'b01, 1'b1, 32'hFFFF_FFFD, 32'd7, n);
    check_eq("madd_lat", 64'(n), 64'd5);
    check_eq("madd_hilo", {32'(hi), 32'(lo)}, 64'hFFFF_FFFF_FFFF_FFFB);

    launch(2'b01, 1'b0, 32'h8000_0000, 32'd2, n);
    check_eq("mult_neg", {32'(hi), 32'(lo)}, 64'hFFFF_FFFF_0000_0000);
    launch(2'b00, 1'b0, 32'h8000_0000, 32'd2, n);
    check_eq("multu_big", {32'(hi), 32'(lo)}, 64'h0000_0001_0000_0000);

    launch(2'b11, 1'b0, 32'hFFFF_FFF9, 32'd2, n);
    check_eq("div_lat", 64'(n), 64'd33);
    check_eq("div_lo", 64'(lo), 64'hFFFF_FFFD);
    check_eq("div_hi", 64'(hi), 64'hFFFF_FFFF);

    launch(2'b11, 1'b1, 32'd7, 32'hFFFF_FFFE, n);
    check_eq("div_negb", {32'(hi), 32'(lo)}, 64'h0000_0001_FFFF_FFFD);

    launch(2'b10, 1'b0, 32'hFFFF_FFFF, 32'h10, n);
    check_eq("divu", {32'(hi), 32'(lo)}, 64'h0000_000F_0FFF_FFFF);

    launch(2'b11, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, n);
    check_eq("div_ovf", {32'(hi), 32'(lo)}, 64'h0000_0000_8000_0000);

    move_to(1'b0, 32'hA);
    move_to(1'b1, 32'hB);
    launch(2'b10, 1'b0, 32'd7, 32'd0, n);
    check_eq("divz_lat", 64'(n), 64'd33);
    check_eq("divz_hilo", {32'(hi), 32'(lo)}, 64'h0000_000A_0000_000B);

    we = 1'b1; hilo = 1'b1; src_a = 32'h1234_5678;
    @(negedge clk);
    we = 1'b0;
    check_eq("mtlo_rd", 64'(rd_data), 64'h1234_5678);
    check_eq("mtlo_busy", 64'(busy), 64'd0);

    move_to(1'b1, 32'h55);
    start = 1'b1; op = 2'b11; src_a = 32'd100; src_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    check_eq("div2_busy", 64'(busy), 64'd1);
    hilo = 1'b1;
    check_eq("rd_pre_op", 64'(rd_data), 64'h55);
    we = 1'b1; src_a = 32'hDEAD; start = 1'b1; op = 2'b01; src_b = 32'd3;
    @(negedge clk);
    we = 1'b0; start = 1'b0;
    n = 1;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    check_eq("div2_lat", 64'(n), 64'd33);
    check_eq("div2_hilo", {32'(hi), 32'(lo)}, 64'h0000_0002_0000_000E);

    launch(2'b00, 1'b0, 32'd3, 32'd4, n);
    check_eq("b2b_lat", 64'(n), 64'd5);
    check_eq("b2b_hilo", {32'(hi), 32'(lo)}, 64'h0000_0000_0000_000C);

    start = 1'b1; op = 2'b11; src_a = 32'd1000; src_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (n < 10) begin
      @(negedge clk);
      n++;
    end
    rst_n = 1'b0;
    #1;
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_hilo", {32'(hi), 32'(lo)}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check_eq("rst_after", {31'd0, busy, hi, lo}, 96'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
